wash_phase_timer: RTL and testbench

//  Timing stage directly upstream of automatic_washing_machine. Watches the controller's phase outputs
//  (soap_wash, water_wash, motor_on, drain_value_on) and times each phase. Generates cycle_timeout and

---
 rtl/washer_pkg.sv | 39 +++
 rtl/wash_phase_timer_tick_gen.sv | 31 +++
 rtl/wash_phase_timer.sv | 112 +++++++++++
 tb/tb_wash_phase_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared encodings for the washing-machine phase timer: the controller phase
// codes, the timer state encoding and the fixed-priority phase decode.
package washer_pkg;

    localparam logic [1:0] PH_NONE  = 2'd0;
    localparam logic [1:0] PH_WASH  = 2'd1;
    localparam logic [1:0] PH_RINSE = 2'd2;
    localparam logic [1:0] PH_SPIN  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WASH    = 3'd1,
        ST_RINSE   = 3'd2,
        ST_SPIN    = 3'd3,
        ST_EXPIRED = 3'd4
    } timer_state_t;

    // Soap wash outranks rinse, which outranks spin (motor and drain together).
    function automatic logic [1:0] decode_phase(input logic soap_wash,
                                                input logic water_wash,
                                                input logic motor_on,
                                                input logic drain_value_on);
        if (soap_wash)                     return PH_WASH;
        else if (water_wash)               return PH_RINSE;
        else if (motor_on && drain_value_on) return PH_SPIN;
        else                               return PH_NONE;
    endfunction

    // Running state that times a given (non-NONE) phase.
    function automatic timer_state_t run_state(input logic [1:0] phase);
        case (phase)
            PH_WASH:  return ST_WASH;
            PH_RINSE: return ST_RINSE;
            PH_SPIN:  return ST_SPIN;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/wash_phase_timer_tick_gen.sv
// tick_gen: PRESCALE down-counter. A synchronous load restarts the count at
// PRESCALE-1; while enabled it counts down and emits a one-cycle tick on the
// cycle it sits at zero, reloading on that same edge.
module tick_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    // Prescaler count: load wins over counting, wraps to RELOAD after zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= RELOAD;
        else if (en)
            cnt <= (cnt == '0) ? RELOAD : cnt - PW'(1);
    end

    assign tick = en && !load && (cnt == '0);

endmodule

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: times the washing-machine controller's phases and feeds
// cycle_timeout / spin_timeout back to it. Entering a new phase loads that
// phase's tick budget; each prescaled tick decrements it, and reaching zero
// latches the matching timeout until the phase changes or goes NONE.
// Optional build macro WASH_TIMER_PAUSE_EN adds a `pause` input that freezes
// counting without blocking phase changes.
module wash_phase_timer
    import washer_pkg::*;
#(
    parameter int PRESCALE    = 1000,
    parameter int WASH_TICKS  = 600,
    parameter int RINSE_TICKS = 400,
    parameter int SPIN_TICKS  = 300,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soap_wash,
    input  logic             water_wash,
    input  logic             motor_on,
    input  logic             drain_value_on,
`ifdef WASH_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic [CNT_W-1:0] remaining,
    output logic             busy
);

    timer_state_t     state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       dec_phase;
    logic             phase_change;
    logic             running;
    logic             hold;
    logic             tick;

    function automatic logic [CNT_W-1:0] phase_ticks(input logic [1:0] phase);
        case (phase)
            PH_WASH:  return CNT_W'(WASH_TICKS);
            PH_RINSE: return CNT_W'(RINSE_TICKS);
            PH_SPIN:  return CNT_W'(SPIN_TICKS);
            default:  return '0;
        endcase
    endfunction

`ifdef WASH_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign dec_phase    = decode_phase(soap_wash, water_wash, motor_on, drain_value_on);
    // phase_q is kept through EXPIRED, so a steady phase never re-arms itself.
    assign phase_change = (dec_phase != PH_NONE) && (dec_phase != phase_q);
    assign running      = (state_q == ST_WASH) || (state_q == ST_RINSE) || (state_q == ST_SPIN);

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .load  (phase_change),
        .en    (running && !hold),
        .tick  (tick)
    );

    // State register: timer state, timed phase and remaining tick count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_NONE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
        end
    end

    // Next state: NONE clears, a phase change reloads (even over a same-edge
    // expiry), otherwise a tick counts down and the 1->0 step expires.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        if (dec_phase == PH_NONE) begin
            state_d = ST_IDLE;
            phase_d = PH_NONE;
            rem_d   = '0;
        end else if (phase_change) begin
            state_d = run_state(dec_phase);
            phase_d = dec_phase;
            rem_d   = phase_ticks(dec_phase);
        end else if (tick && (rem_q != '0)) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1))
                state_d = ST_EXPIRED;
        end
    end

    // Outputs decoded from registered state only, so none depend on inputs.
    always_comb begin
        busy          = running;
        remaining     = rem_q;
        cycle_timeout = (state_q == ST_EXPIRED) && ((phase_q == PH_WASH) || (phase_q == PH_RINSE));
        spin_timeout  = (state_q == ST_EXPIRED) && (phase_q == PH_SPIN);
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Bench for wash_phase_timer: directed phase scenarios followed by randomized
// phase traffic, every edge checked against an edge-count reference model.
module tb_wash_phase_timer;

    localparam int P  = 4;
    localparam int WT = 3;
    localparam int RT = 2;
    localparam int ST = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          soap_wash = 1'b0;
    logic          water_wash = 1'b0;
    logic          motor_on = 1'b0;
    logic          drain_value_on = 1'b0;
    logic          pause = 1'b0;
    logic          cycle_timeout;
    logic          spin_timeout;
    logic [CW-1:0] remaining;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Reference model: phase being timed, clock edges left until expiry, expired flag.
    int m_phase = 0;
    int m_left  = 0;
    bit m_exp   = 1'b0;

    wash_phase_timer #(
        .PRESCALE    (P),
        .WASH_TICKS  (WT),
        .RINSE_TICKS (RT),
        .SPIN_TICKS  (ST),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .soap_wash      (soap_wash),
        .water_wash     (water_wash),
        .motor_on       (motor_on),
        .drain_value_on (drain_value_on),
`ifdef WASH_TIMER_PAUSE_EN
        .pause          (pause),
`endif
        .cycle_timeout  (cycle_timeout),
        .spin_timeout   (spin_timeout),
        .remaining      (remaining),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic int ticks_of(input int ph);
        case (ph)
            1:       return WT;
            2:       return RT;
            3:       return ST;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_exp   = 1'b0;
    endtask

    task automatic model_edge();
        int dec;
        dec = soap_wash ? 1 : water_wash ? 2 : (motor_on && drain_value_on) ? 3 : 0;
        if (dec == 0) begin
            model_reset();
        end else if (dec != m_phase) begin
            m_phase = dec;
            m_exp   = 1'b0;
            m_left  = ticks_of(dec) * P;
        end else if (!m_exp && !pause) begin
            m_left--;
            if (m_left == 0) m_exp = 1'b1;
        end
    endtask

    task automatic check(input string tag);
        logic          e_cto, e_sto, e_busy;
        logic [CW-1:0] e_rem;
        e_cto  = m_exp && (m_phase == 1 || m_phase == 2);
        e_sto  = m_exp && (m_phase == 3);
        e_busy = (m_phase != 0) && !m_exp;
        e_rem  = m_exp ? '0 : CW'((m_left + P - 1) / P);
        total++;
        assert (cycle_timeout === e_cto) else begin
            bad++; $error("FAIL %s cycle_timeout got=%0b want=%0b", tag, cycle_timeout, e_cto);
        end
        total++;
        assert (spin_timeout === e_sto) else begin
            bad++; $error("FAIL %s spin_timeout got=%0b want=%0b", tag, spin_timeout, e_sto);
        end
        total++;
        assert (busy === e_busy) else begin
            bad++; $error("FAIL %s busy got=%0b want=%0b", tag, busy, e_busy);
        end
        total++;
        assert (remaining === e_rem) else begin
            bad++; $error("FAIL %s remaining got=%0d want=%0d", tag, remaining, e_rem);
        end
    endtask

    // Direct comparison against a value fixed by the scenario itself.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++; $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset) model_edge();
        #1;
        check(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic set_in(input logic s, input logic w, input logic m, input logic d);
        soap_wash = s; water_wash = w; motor_on = m; drain_value_on = d;
    endtask

    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check(tag);
        step(tag);
        reset = 1'b1;
    endtask

    initial begin
        // 1: held in reset with soap_wash up, then release
        set_in(1, 0, 0, 0);
        #1;
        check("rst_hold");
        steps("rst_hold", 3);
        reset = 1'b1;
        step("rst_release");
        chk("rst_entry_busy", busy, 1);
        chk("rst_entry_rem", remaining, 3);

        // 2: steady wash expires 12 edges after entry and holds
        steps("wash_run", 11);
        chk("wash_pre_timeout", cycle_timeout, 0);
        step("wash_run");
        chk("wash_timeout_12", cycle_timeout, 1);
        steps("wash_hold", 3);
        chk("wash_timeout_held", cycle_timeout, 1);
        set_in(0, 0, 0, 0);
        step("wash_drop");
        chk("wash_drop_cto", cycle_timeout, 0);
        chk("wash_drop_rem", remaining, 0);

        // 3: wash -> rinse at edge 6 reloads without a timeout
        set_in(1, 0, 0, 0);
        step("w2r_entry");
        steps("w2r_wash", 5);
        set_in(0, 1, 0, 0);
        step("w2r_switch");
        chk("w2r_reload_rem", remaining, 2);
        chk("w2r_no_timeout", cycle_timeout, 0);
        steps("rinse_run", 7);
        chk("rinse_pre_timeout", cycle_timeout, 0);
        step("rinse_run");
        chk("rinse_timeout_8", cycle_timeout, 1);

        // 4: spin expires after 8 edges, only spin_timeout rises
        set_in(0, 0, 0, 0);
        step("idle");
        set_in(0, 0, 1, 1);
        step("spin_entry");
        steps("spin_run", 7);
        chk("spin_pre_timeout", spin_timeout, 0);
        step("spin_run");
        chk("spin_timeout_8", spin_timeout, 1);
        chk("spin_no_cycle", cycle_timeout, 0);

        // 5: soap and water together pick wash; reset mid-phase restarts full count
        set_in(1, 1, 0, 0);
        step("prio_entry");
        chk("prio_rem", remaining, 3);
        steps("prio_run", 4);
        reset_pulse("mid_reset");
        chk("mid_reset_busy", busy, 0);
        step("prio_reentry");
        chk("prio_reentry_rem", remaining, 3);
        steps("prio_run2", 11);
        chk("prio_pre_timeout", cycle_timeout, 0);
        step("prio_run2");
        chk("prio_timeout_12", cycle_timeout, 1);

`ifdef WASH_TIMER_PAUSE_EN
        // 6: five paused edges mid-wash delay expiry to 17 edges
        set_in(0, 0, 0, 0);
        step("idle");
        set_in(1, 0, 0, 0);
        step("pause_entry");
        steps("pause_run", 3);
        pause = 1'b1;
        steps("pause_hold", 5);
        pause = 1'b0;
        steps("pause_run", 8);
        chk("pause_pre_timeout", cycle_timeout, 0);
        step("pause_run");
        chk("pause_timeout_17", cycle_timeout, 1);
`endif

        // Randomized phase traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                logic [3:0] r;
                r = 4'($urandom);
                set_in(r[0], r[1], r[2], r[3]);
            end
`ifdef WASH_TIMER_PAUSE_EN
            pause = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 399) == 0)
                reset_pulse("rand_reset");
            else
                step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
